// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: drives the program counter, issues instruction-memory reads and
// queues fetched words in a 2-entry FIFO for decode. Optional trap macro: FETCH_MISALIGN_TRAP_EN.
module instruction_fetch_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic [63:0] pc_cur,
    output logic [63:0] pc_next,
    output logic        mem_req,
    output logic [63:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    input  logic        redirect,
    input  logic [63:0] redirect_target,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [63:0] instr_pc,
    output logic        misalign
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT_Q, FAULT} state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_q_data [2];
    logic [63:0] r_q_pc   [2];
    logic        r_rd_ptr;
    logic        r_wr_ptr;
    logic [1:0]  r_count;
    logic [63:0] w_fetch_pc;
    logic        w_misaligned;
    logic        w_push;
    logic        w_pop;

`ifdef FETCH_MISALIGN_TRAP_EN
    assign w_fetch_pc   = pc_cur;
    assign w_misaligned = (pc_cur[1:0] != 2'b00);
`else
    // Without the trap, low PC bits are simply ignored for fetch and reporting.
    assign w_fetch_pc   = {pc_cur[63:2], 2'b00};
    assign w_misaligned = 1'b0;
`endif

    assign mem_addr    = w_fetch_pc;
    assign instr_valid = (r_count != 2'd0);
    assign instr       = r_q_data[r_rd_ptr];
    assign instr_pc    = r_q_pc[r_rd_ptr];
    assign w_pop       = instr_valid && instr_ready && !redirect;
    assign w_push      = mem_req && mem_ack && !redirect;

    always_comb begin
        w_state_nxt = r_state;
        mem_req     = 1'b0;
        pc_next     = pc_cur;
        misalign    = 1'b0;
        case (r_state)
            IDLE: w_state_nxt = REQ;
            REQ: begin
                if (w_misaligned) begin
                    w_state_nxt = FAULT;
                end else begin
                    mem_req = 1'b1;
                    if (mem_ack) begin
                        pc_next = w_fetch_pc + 64'd4;
                        // Second entry lands with nobody draining: stall until decode pops.
                        if (r_count == 2'd1 && !w_pop)
                            w_state_nxt = WAIT_Q;
                    end
                end
            end
            WAIT_Q: begin
                if (w_pop)
                    w_state_nxt = REQ;
            end
            FAULT: begin
`ifdef FETCH_MISALIGN_TRAP_EN
                misalign = 1'b1;
`endif
                w_state_nxt = FAULT;
            end
        endcase
        if (redirect) begin
            pc_next     = redirect_target;
            w_state_nxt = REQ;
        end
        if (reset)
            pc_next = 64'd0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_state <= IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 2; i++) begin
                r_q_data[i] <= 32'd0;
                r_q_pc[i]   <= 64'd0;
            end
            r_rd_ptr <= 1'b0;
            r_wr_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else if (redirect) begin
            r_rd_ptr <= 1'b0;
            r_wr_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_push) begin
                r_q_data[r_wr_ptr] <= mem_rdata;
                r_q_pc[r_wr_ptr]   <= w_fetch_pc;
                r_wr_ptr           <= ~r_wr_ptr;
            end
            if (w_pop)
                r_rd_ptr <= ~r_rd_ptr;
            r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
        end
    end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench for instruction_fetch_unit: directed scenarios plus a randomized run
// scored against a queue-based model of the fetch rules.
module tb_instruction_fetch_unit;

`ifdef FETCH_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [63:0] pc_cur = 64'd0;
    logic [63:0] pc_next;
    logic        mem_req;
    logic [63:0] mem_addr;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata;
    logic        redirect = 1'b0;
    logic [63:0] redirect_target = 64'd0;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic [31:0] instr;
    logic [63:0] instr_pc;
    logic        misalign;

    int checks = 0;
    int errors = 0;

    instruction_fetch_unit dut (
        .clk(clk), .reset(reset), .pc_cur(pc_cur), .pc_next(pc_next),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .redirect(redirect), .redirect_target(redirect_target),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
        .instr_pc(instr_pc), .misalign(misalign)
    );

    always #5 clk = ~clk;

    // Program counter register: loads pc_next every edge.
    always @(posedge clk) pc_cur <= pc_next;

    function automatic logic [31:0] memf(input logic [63:0] a);
        return (a[31:0] * 32'h9E37_79B1) ^ a[63:32] ^ 32'h5A5A_0F0F;
    endfunction

    assign mem_rdata = mem_ack ? memf(mem_addr) : 32'hDEAD_BEEF;

    // Reference model: fetch PC, pending instruction queue, start-up and fault flags.
    logic [63:0] m_qpc [$];
    logic [31:0] m_qd  [$];
    logic [63:0] m_pc    = 64'd0;
    bit          m_idle  = 1'b1;
    bit          m_fault = 1'b0;

    function automatic logic [63:0] align(input logic [63:0] a);
        return {a[63:2], 2'b00};
    endfunction

    function automatic bit m_req();
        return !m_idle && !m_fault && (m_qpc.size() < 2) && !(TRAP && (m_pc[1:0] != 2'b00));
    endfunction

    function automatic logic [63:0] m_pc_next();
        if (reset) return 64'd0;
        if (redirect) return redirect_target;
        if (m_req() && mem_ack) return align(m_pc) + 64'd4;
        return m_pc;
    endfunction

    task automatic model_update();
        bit req;
        if (reset) begin
            m_qpc.delete(); m_qd.delete();
            m_pc = 64'd0; m_idle = 1'b1; m_fault = 1'b0;
        end else if (redirect) begin
            m_qpc.delete(); m_qd.delete();
            m_pc = redirect_target; m_idle = 1'b0; m_fault = 1'b0;
        end else begin
            req = m_req();
            if (m_idle)
                m_idle = 1'b0;
            else if (TRAP && !m_fault && m_qpc.size() < 2 && m_pc[1:0] != 2'b00)
                m_fault = 1'b1;
            if (m_qpc.size() > 0 && instr_ready) begin
                void'(m_qpc.pop_front());
                void'(m_qd.pop_front());
            end
            if (req && mem_ack) begin
                m_qpc.push_back(align(m_pc));
                m_qd.push_back(memf(align(m_pc)));
                m_pc = align(m_pc) + 64'd4;
            end
        end
    endtask

    task automatic tick();
        model_update();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        reset = 1'b1; mem_ack = 1'b0; redirect = 1'b0; instr_ready = 1'b0;
        tick(); tick();
        reset = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        #1 reset = 1'b1;
        #1;
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL reset_mem_req: got %b want 0", mem_req); end
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL reset_instr_valid: got %b want 0", instr_valid); end
        checks++; if (instr !== 32'd0) begin errors++; $display("FAIL reset_instr: got %h want 0", instr); end
        checks++; if (instr_pc !== 64'd0) begin errors++; $display("FAIL reset_instr_pc: got %h want 0", instr_pc); end
        checks++; if (pc_next !== 64'd0) begin errors++; $display("FAIL reset_pc_next: got %h want 0", pc_next); end
        checks++; if (misalign !== 1'b0) begin errors++; $display("FAIL reset_misalign: got %b want 0", misalign); end
        mem_ack = 1'b1;
        tick(); tick();
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL reset_hold_mem_req: got %b want 0", mem_req); end
        mem_ack = 1'b0;
        reset = 1'b0;
        #1;
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL release_idle_req: got %b want 0", mem_req); end
        checks++; if (pc_next !== 64'd0) begin errors++; $display("FAIL release_idle_pc_next: got %h want 0", pc_next); end
        tick();
        #1;
        checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL first_req: got %b want 1", mem_req); end
        checks++; if (mem_addr !== 64'd0) begin errors++; $display("FAIL first_addr: got %h want 0", mem_addr); end
    endtask

    task automatic test_stream();
        apply_reset();
        mem_ack = 1'b1; instr_ready = 1'b1;
        #1;
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL stream_idle_req: got %b want 0", mem_req); end
        tick();
        for (int k = 0; k < 6; k++) begin
            #1;
            checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL stream_req[%0d]: got %b want 1", k, mem_req); end
            checks++; if (mem_addr !== 64'(4 * k)) begin errors++; $display("FAIL stream_addr[%0d]: got %h want %h", k, mem_addr, 64'(4 * k)); end
            checks++; if (pc_next !== 64'(4 * k + 4)) begin errors++; $display("FAIL stream_pc_next[%0d]: got %h want %h", k, pc_next, 64'(4 * k + 4)); end
            if (k > 0) begin
                checks++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL stream_valid[%0d]: got %b want 1", k, instr_valid); end
                checks++; if (instr_pc !== 64'(4 * (k - 1))) begin errors++; $display("FAIL stream_instr_pc[%0d]: got %h want %h", k, instr_pc, 64'(4 * (k - 1))); end
                checks++; if (instr !== memf(64'(4 * (k - 1)))) begin errors++; $display("FAIL stream_instr[%0d]: got %h want %h", k, instr, memf(64'(4 * (k - 1)))); end
            end
            tick();
        end
    endtask

    task automatic test_backpressure();
        apply_reset();
        mem_ack = 1'b1; instr_ready = 1'b0;
        tick();
        #1;
        checks++; if (mem_addr !== 64'd0 || mem_req !== 1'b1) begin errors++; $display("FAIL bp_req0: got req=%b addr=%h want 1/0", mem_req, mem_addr); end
        tick();
        #1;
        checks++; if (mem_addr !== 64'd4 || mem_req !== 1'b1) begin errors++; $display("FAIL bp_req4: got req=%b addr=%h want 1/4", mem_req, mem_addr); end
        tick();
        #1;
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL bp_wait_req: got %b want 0", mem_req); end
        checks++; if (pc_cur !== 64'd8) begin errors++; $display("FAIL bp_wait_pc: got %h want 8", pc_cur); end
        checks++; if (instr_valid !== 1'b1 || instr_pc !== 64'd0) begin errors++; $display("FAIL bp_head: got v=%b pc=%h want 1/0", instr_valid, instr_pc); end
        tick();
        #1;
        checks++; if (mem_req !== 1'b0 || pc_cur !== 64'd8) begin errors++; $display("FAIL bp_hold: got req=%b pc=%h want 0/8", mem_req, pc_cur); end
        instr_ready = 1'b1;
        #1;
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL bp_pop_cycle_req: got %b want 0", mem_req); end
        tick();
        instr_ready = 1'b0; mem_ack = 1'b0;
        #1;
        checks++; if (mem_req !== 1'b1 || mem_addr !== 64'd8) begin errors++; $display("FAIL bp_resume: got req=%b addr=%h want 1/8", mem_req, mem_addr); end
        checks++; if (instr_pc !== 64'd4) begin errors++; $display("FAIL bp_resume_head: got %h want 4", instr_pc); end
    endtask

    task automatic test_redirect();
        apply_reset();
        tick();
        mem_ack = 1'b1; instr_ready = 1'b0;
        tick();
        redirect = 1'b1; redirect_target = 64'h20;
        #1;
        checks++; if (pc_next !== 64'h20) begin errors++; $display("FAIL redir_pc_next: got %h want 20", pc_next); end
        tick();
        redirect = 1'b0; mem_ack = 1'b0;
        #1;
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL redir_flush: got %b want 0", instr_valid); end
        checks++; if (mem_req !== 1'b1 || mem_addr !== 64'h20) begin errors++; $display("FAIL redir_req20: got req=%b addr=%h want 1/20", mem_req, mem_addr); end
        mem_ack = 1'b1; redirect = 1'b1; redirect_target = 64'h1000;
        #1;
        checks++; if (pc_next !== 64'h1000) begin errors++; $display("FAIL redir_ack_pc_next: got %h want 1000", pc_next); end
        tick();
        redirect = 1'b0; mem_ack = 1'b0;
        #1;
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL redir_drop: got %b want 0", instr_valid); end
        checks++; if (mem_req !== 1'b1 || mem_addr !== 64'h1000) begin errors++; $display("FAIL redir_req1000: got req=%b addr=%h want 1/1000", mem_req, mem_addr); end
        tick();
    endtask

    task automatic test_wrap();
        redirect = 1'b1; redirect_target = 64'hFFFF_FFFF_FFFF_FFFC; mem_ack = 1'b0;
        tick();
        redirect = 1'b0; mem_ack = 1'b1; instr_ready = 1'b1;
        #1;
        checks++; if (mem_addr !== 64'hFFFF_FFFF_FFFF_FFFC) begin errors++; $display("FAIL wrap_addr: got %h want fffffffffffffffc", mem_addr); end
        checks++; if (pc_next !== 64'd0) begin errors++; $display("FAIL wrap_pc_next: got %h want 0", pc_next); end
        tick();
        mem_ack = 1'b0;
        #1;
        checks++; if (mem_req !== 1'b1 || mem_addr !== 64'd0) begin errors++; $display("FAIL wrap_next_req: got req=%b addr=%h want 1/0", mem_req, mem_addr); end
        checks++; if (instr_valid !== 1'b1 || instr_pc !== 64'hFFFF_FFFF_FFFF_FFFC) begin errors++; $display("FAIL wrap_head: got v=%b pc=%h", instr_valid, instr_pc); end
        tick();
    endtask

    task automatic test_misalign();
        redirect = 1'b1; redirect_target = 64'h1002; mem_ack = 1'b0; instr_ready = 1'b0;
        tick();
        redirect = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
        mem_ack = 1'b1;
        #1;
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL mis_no_req: got %b want 0", mem_req); end
        tick();
        #1;
        checks++; if (misalign !== 1'b1 || mem_req !== 1'b0) begin errors++; $display("FAIL mis_fault: got mis=%b req=%b want 1/0", misalign, mem_req); end
        checks++; if (pc_next !== 64'h1002) begin errors++; $display("FAIL mis_pc_hold: got %h want 1002", pc_next); end
        tick();
        #1;
        checks++; if (misalign !== 1'b1 || mem_req !== 1'b0) begin errors++; $display("FAIL mis_stuck: got mis=%b req=%b want 1/0", misalign, mem_req); end
        redirect = 1'b1; redirect_target = 64'h2000;
        tick();
        redirect = 1'b0; mem_ack = 1'b0;
        #1;
        checks++; if (misalign !== 1'b0 || mem_req !== 1'b1 || mem_addr !== 64'h2000) begin errors++; $display("FAIL mis_exit: got mis=%b req=%b addr=%h want 0/1/2000", misalign, mem_req, mem_addr); end
`else
        #1;
        checks++; if (mem_req !== 1'b1 || mem_addr !== 64'h1000) begin errors++; $display("FAIL mis_aligned_req: got req=%b addr=%h want 1/1000", mem_req, mem_addr); end
        checks++; if (misalign !== 1'b0) begin errors++; $display("FAIL mis_tied: got %b want 0", misalign); end
        mem_ack = 1'b1;
        #1;
        checks++; if (pc_next !== 64'h1004) begin errors++; $display("FAIL mis_pc_next: got %h want 1004", pc_next); end
        tick();
        mem_ack = 1'b0;
        #1;
        checks++; if (instr_pc !== 64'h1000 || instr_valid !== 1'b1) begin errors++; $display("FAIL mis_instr_pc: got v=%b pc=%h want 1/1000", instr_valid, instr_pc); end
`endif
        tick();
    endtask

    task automatic test_reset_mid();
        apply_reset();
        tick();
        mem_ack = 1'b1; instr_ready = 1'b0;
        tick();
        mem_ack = 1'b0;
        #1;
        checks++; if (mem_req !== 1'b1 || instr_valid !== 1'b1 || mem_addr !== 64'd4) begin errors++; $display("FAIL mid_pre: got req=%b v=%b addr=%h want 1/1/4", mem_req, instr_valid, mem_addr); end
        reset = 1'b1;
        #1;
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL mid_abort_req: got %b want 0", mem_req); end
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL mid_abort_valid: got %b want 0", instr_valid); end
        checks++; if (pc_next !== 64'd0) begin errors++; $display("FAIL mid_abort_pc_next: got %h want 0", pc_next); end
        tick(); tick();
        reset = 1'b0;
        #1;
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL mid_idle: got %b want 0", mem_req); end
        tick();
        #1;
        checks++; if (mem_req !== 1'b1 || mem_addr !== 64'd0) begin errors++; $display("FAIL mid_restart: got req=%b addr=%h want 1/0", mem_req, mem_addr); end
    endtask

    task automatic test_random();
        apply_reset();
        for (int i = 0; i < 400; i++) begin
            mem_ack     = ($urandom_range(0, 9) < 6);
            instr_ready = 1'($urandom_range(0, 1));
            redirect    = ($urandom_range(0, 24) == 0);
            if ($urandom_range(0, 3) == 0)
                redirect_target = 64'hFFFF_FFFF_FFFF_FFF0 + 64'($urandom_range(0, 3) * 4);
            else
                redirect_target = {$urandom, $urandom} & 64'hFFFF_FFFF_FFFF_FFFC;
            #1;
            checks++; if (mem_req !== m_req()) begin errors++; $display("FAIL rnd_mem_req[%0d]: got %b want %b", i, mem_req, m_req()); end
            checks++; if (mem_addr !== align(m_pc)) begin errors++; $display("FAIL rnd_mem_addr[%0d]: got %h want %h", i, mem_addr, align(m_pc)); end
            checks++; if (pc_next !== m_pc_next()) begin errors++; $display("FAIL rnd_pc_next[%0d]: got %h want %h", i, pc_next, m_pc_next()); end
            checks++; if (instr_valid !== (m_qpc.size() > 0)) begin errors++; $display("FAIL rnd_valid[%0d]: got %b want %b", i, instr_valid, m_qpc.size() > 0); end
            if (m_qpc.size() > 0) begin
                checks++; if (instr_pc !== m_qpc[0]) begin errors++; $display("FAIL rnd_instr_pc[%0d]: got %h want %h", i, instr_pc, m_qpc[0]); end
                checks++; if (instr !== m_qd[0]) begin errors++; $display("FAIL rnd_instr[%0d]: got %h want %h", i, instr, m_qd[0]); end
            end
            checks++; if (misalign !== m_fault) begin errors++; $display("FAIL rnd_misalign[%0d]: got %b want %b", i, misalign, m_fault); end
            tick();
        end
        redirect = 1'b0; mem_ack = 1'b0;
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect();
        test_wrap();
        test_misalign();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/instruction_fetch_unit.md
INSTRUCTION_FETCH_UNIT -- requirements
Module: instruction_fetch_unit

Interface
REQ-001 SHALL have port clk, input, 1: sole clock; all state updates on its rising edge.
REQ-002 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-003 SHALL have port pc_cur, input, 64: current PC, driven by the program counter's PC_Out.
REQ-004 SHALL have port pc_next, output, 64: next PC, driving the program counter's PC_In; the counter loads it every clk edge.
REQ-005 SHALL have port mem_req, output, 1: instruction-memory read request.
REQ-006 SHALL have port mem_addr, output, 64: byte read address.
REQ-007 SHALL have port mem_ack, input, 1: read complete; may assert in the same cycle as mem_req.
REQ-008 SHALL have port mem_rdata, input, 32: instruction word, valid while mem_ack=1.
REQ-009 SHALL have port redirect, input, 1: branch/jump taken; flush the queue and refetch.
REQ-010 SHALL have port redirect_target, input, 64: new PC, sampled when redirect=1.
REQ-011 SHALL have port instr_valid, output, 1: queue head valid.
REQ-012 SHALL have port instr_ready, input, 1: decode accepts the head.
REQ-013 SHALL have port instr, output, 32: head instruction word.
REQ-014 SHALL have port instr_pc, output, 64: PC of the head instruction.
REQ-015 SHALL have port misalign, output, 1: misaligned-fetch fault flag (see Configuration).

Function
REQ-016 SHALL implement FSM states IDLE, REQ, WAIT_Q and FAULT.
REQ-017 IDLE: mem_req=0 and pc_next=pc_cur; next state is unconditionally REQ.
REQ-018 REQ: mem_req=1 and mem_addr=pc_cur; both are held stable until mem_ack or redirect.
REQ-019 REQ with mem_ack=1 and no redirect:
- push {pc_cur, mem_rdata} into the queue;
- pc_next=pc_cur+4;
- go to WAIT_Q if the queue is full after the push and no pop occurs that cycle, else stay in REQ.
REQ-020 REQ with mem_ack=0: pc_next=pc_cur.
REQ-021 WAIT_Q: mem_req=0 and pc_next=pc_cur; go to REQ in the cycle after a pop.
REQ-022 pc+4 SHALL wrap modulo 2^64 (0xFFFF_FFFF_FFFF_FFFC -> 0); no carry out.
REQ-023 Queue: 2-entry FIFO.
- instr_valid = queue not empty; instr and instr_pc show the head entry.
- Pop when instr_valid and instr_ready.
REQ-024 Simultaneous push and pop SHALL keep the count unchanged and preserve order.
REQ-025 Push into a full queue SHALL never occur (guaranteed by WAIT_Q); pop from empty is a no-op.
REQ-026 Redirect has priority over mem_ack and pop:
- flush the queue (instr_valid=0 next cycle);
- discard any same-cycle mem_rdata;
- pc_next=redirect_target;
- next state REQ from any state, including FAULT.
REQ-027 Instruction latency: mem_ack in cycle N -> instr_valid=1 in cycle N+1 with the captured data.
REQ-028 mem_addr SHALL equal pc_cur in all states; mem_req is the only qualifier.

Reset
REQ-029 While reset=1:
- state=IDLE, queue empty;
- mem_req=0, instr_valid=0, instr=0, instr_pc=0;
- pc_next=0, misalign=0.
REQ-030 Reset assertion mid-transaction SHALL abort immediately, with no memory handshake completion required.
REQ-031 The first mem_req SHALL occur in the second cycle after reset deassertion (IDLE, then REQ) with mem_addr=0.

Configuration
REQ-032 Macro FETCH_MISALIGN_TRAP_EN, when defined:
- REQ with pc_cur[1:0]!=0 SHALL enter FAULT instead of requesting;
- FAULT: misalign=1, mem_req=0, pc_next=pc_cur;
- FAULT is left only by redirect or reset.
REQ-033 When FETCH_MISALIGN_TRAP_EN is undefined:
- mem_addr[1:0] forced to 0;
- instr_pc reports the aligned address;
- misalign tied 0;
- FAULT unreachable.

Verification
REQ-034 Reset release, mem_ack same-cycle, instr_ready=1 -> requests at 0,4,8,...; instr_pc sequence 0,4,8; pc_next one step ahead.
REQ-035 instr_ready=0, continuous acks -> two entries (PC 0,4) queued, then WAIT_Q, mem_req=0, pc_cur held at 8; one pop -> request at 8 next cycle.
REQ-036 redirect=1 with target 0x1000 in the same cycle as mem_ack at 0x20 -> word at 0x20 dropped, queue empty, next request addr 0x1000.
REQ-037 pc_cur=0xFFFF_FFFF_FFFF_FFFC acked -> pc_next=0, next request addr 0.
REQ-038 redirect_target 0x1002:
- with macro -> misalign=1 and no mem_req until redirect to 0x2000;
- without macro -> request at 0x1000.
REQ-039 reset pulsed while in REQ awaiting ack -> mem_req=0 and instr_valid=0 immediately; restart at addr 0.
